// File: rtl/sga_input_conditioner.sv
// Snake Game Arcade input front-end: synchronises and debounces six raw buttons,
// converts presses into single-cycle pulses and gates direction presses through a
// one-entry buffer while the control unit is not waiting for a move.
module sga_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       accept_dir,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       played,
  output logic       start,
  output logic       pause,
  output logic       pending_valid,
  output logic [5:0] db_levels
);

  localparam int unsigned NumBtn = 6;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions, shared by every 6-bit vector below.
  localparam int unsigned BLeft  = 0;
  localparam int unsigned BRight = 1;
  localparam int unsigned BUp    = 2;
  localparam int unsigned BDown  = 3;
  localparam int unsigned BStart = 4;
  localparam int unsigned BPause = 5;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] db_q, db_d;
  logic [NumBtn-1:0] db_prev_q;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [CNT_W-1:0]  cnt_d [NumBtn];
  logic [NumBtn-1:0] press;

  // Direction vectors use the low four button bits: {down, up, right, left}.
  logic [3:0] new_dir;
  logic [3:0] dir_q, dir_d;
  logic [3:0] pend_dir_q, pend_dir_d;
  logic       pend_valid_q, pend_valid_d;
  logic       played_q, played_d;
  logic       start_q, start_d;
  logic       pause_q, pause_d;

  assign raw = {btn_pause, btn_start, btn_down, btn_up, btn_right, btn_left};

  // Two-stage synchroniser per button.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level must differ for DEBOUNCE_CYCLES consecutive cycles to be accepted.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounced levels, their delayed copy for edge detection, and the counters.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = db_q & ~db_prev_q;

  // Same-cycle direction presses collapse to one: left > up > down > right.
  always_comb begin
    new_dir = 4'b0000;
    if (press[BLeft]) begin
      new_dir[BLeft] = 1'b1;
    end else if (press[BUp]) begin
      new_dir[BUp] = 1'b1;
    end else if (press[BDown]) begin
      new_dir[BDown] = 1'b1;
    end else if (press[BRight]) begin
      new_dir[BRight] = 1'b1;
    end
  end

  // Gating: emit while the control unit waits, otherwise hold the newest press.
  always_comb begin
    dir_d        = 4'b0000;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    if (accept_dir) begin
      if (|new_dir) begin
        // A fresh press wins; any older buffered entry is dropped.
        dir_d        = new_dir;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        dir_d        = pend_dir_q;
        pend_valid_d = 1'b0;
      end
    end else if (|new_dir) begin
      pend_dir_d   = new_dir;
      pend_valid_d = 1'b1;
    end
    played_d = |dir_d;
    start_d  = press[BStart];
    pause_d  = press[BPause];
  end

  // Registered pulse outputs and the pending-direction buffer.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      dir_q        <= '0;
      pend_dir_q   <= '0;
      pend_valid_q <= 1'b0;
      played_q     <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      played_q     <= played_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
    end
  end

  assign left          = dir_q[BLeft];
  assign right         = dir_q[BRight];
  assign up            = dir_q[BUp];
  assign down          = dir_q[BDown];
  assign played        = played_q;
  assign start         = start_q;
  assign pause         = pause_q;
  assign pending_valid = pend_valid_q;
  assign db_levels     = db_q;

endmodule

// File: tb/tb_sga_input_conditioner.sv
// Scoreboard bench for sga_input_conditioner with DEBOUNCE_CYCLES=4.
// Output vectors are {pause,start,down,up,right,left,played}.
module tb_sga_input_conditioner;

  localparam int unsigned D = 4;

  localparam logic [6:0] VLeft  = 7'b0000011;
  localparam logic [6:0] VRight = 7'b0000101;
  localparam logic [6:0] VSP    = 7'b1100000;

  logic       clock = 1'b0;
  logic       restart_n;
  logic [5:0] btn;  // {pause,start,down,up,right,left}
  logic       accept_dir;
  logic       left, right, up, down, played, start, pause, pending_valid;
  logic [5:0] db_levels;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cycle;
    logic [6:0] vec;
  } exp_t;
  exp_t exp_q[$];

  sga_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clock        (clock),
    .restart_n    (restart_n),
    .btn_left     (btn[0]),
    .btn_right    (btn[1]),
    .btn_up       (btn[2]),
    .btn_down     (btn[3]),
    .btn_start    (btn[4]),
    .btn_pause    (btn[5]),
    .accept_dir   (accept_dir),
    .left         (left),
    .right        (right),
    .up           (up),
    .down         (down),
    .played       (played),
    .start        (start),
    .pause        (pause),
    .pending_valid(pending_valid),
    .db_levels    (db_levels)
  );

  always #5 clock = ~clock;

  // After the n-th rising edge, cyc == n.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [6:0] out_vec();
    return {pause, start, down, up, right, left, played};
  endfunction

  // Monitor: any pulse must match the oldest expectation, both value and cycle.
  always @(negedge clock) begin
    if (restart_n && (out_vec() != 7'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, out_vec());
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.vec != out_vec() || e.cycle != cyc) begin
          errors++;
          $display("FAIL pulse got=%b@%0d required=%b@%0d", out_vec(), cyc, e.vec, e.cycle);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Inputs applied now are stable before edge cyc+1; the pulse shows after edge k+D+2.
  task automatic expect_press(input logic [6:0] vec, output int k);
    k = cyc + 1;
    exp_q.push_back('{cycle: k + D + 2, vec: vec});
  endtask

  int k, r;

  initial begin
    restart_n  = 1'b0;
    btn        = '0;
    accept_dir = 1'b1;
    idle(3);
    check("reset_outs", {25'd0, out_vec()}, 32'd0);
    check("reset_db", {26'd0, db_levels}, 32'd0);
    check("reset_pend", {31'd0, pending_valid}, 32'd0);
    restart_n = 1'b1;
    idle(2);

    // 1: left held -> one pulse, debounced level rises at edge k+D+1.
    btn[0] = 1'b1;
    expect_press(VLeft, k);
    wait_cyc(k + D);
    check("db_left_before", {31'd0, db_levels[0]}, 32'd0);
    wait_cyc(k + D + 1);
    check("db_left_after", {31'd0, db_levels[0]}, 32'd1);
    idle(4);
    btn[0] = 1'b0;
    idle(D + 6);
    check("db_left_released", {26'd0, db_levels}, 32'd0);

    // 2: three-cycle glitch on up is filtered.
    btn[2] = 1'b1;
    idle(3);
    btn[2] = 1'b0;
    idle(D + 6);
    check("glitch_db", {26'd0, db_levels}, 32'd0);

    // 3: left and down together -> left only.
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    expect_press(VLeft, k);
    idle(D + 6);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    idle(D + 6);

    // 4: gated down then right; right emitted once accept_dir rises.
    accept_dir = 1'b0;
    btn[3] = 1'b1;
    k = cyc + 1;
    wait_cyc(k + D + 1);
    check("pend_before", {31'd0, pending_valid}, 32'd0);
    wait_cyc(k + D + 2);
    check("pend_down", {31'd0, pending_valid}, 32'd1);
    btn[3] = 1'b0;
    idle(D + 6);
    btn[1] = 1'b1;
    idle(D + 6);
    btn[1] = 1'b0;
    idle(D + 6);
    check("pend_right", {31'd0, pending_valid}, 32'd1);
    accept_dir = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{cycle: r, vec: VRight});
    wait_cyc(r);
    check("pend_cleared", {31'd0, pending_valid}, 32'd0);
    idle(4);

    // 5: start and pause together while gated.
    accept_dir = 1'b0;
    btn[5:4] = 2'b11;
    expect_press(VSP, k);
    idle(D + 6);
    btn[5:4] = 2'b00;
    idle(D + 6);
    check("pend_after_sp", {31'd0, pending_valid}, 32'd0);

    // 6: right held across resets after a pulse and mid-count.
    accept_dir = 1'b1;
    btn[1] = 1'b1;
    expect_press(VRight, k);
    wait_cyc(k + D + 4);
    check("db_right_held", {31'd0, db_levels[1]}, 32'd1);
    restart_n = 1'b0;
    #1;
    check("rst_outs", {25'd0, out_vec()}, 32'd0);
    check("rst_db", {26'd0, db_levels}, 32'd0);
    idle(2);
    restart_n = 1'b1;
    idle(3);
    restart_n = 1'b0;
    #1;
    check("rst_mid_db", {26'd0, db_levels}, 32'd0);
    idle(2);
    restart_n = 1'b1;
    expect_press(VRight, k);
    idle(D + 8);
    btn[1] = 1'b0;
    idle(D + 6);

    check("queue_drained", exp_q.size(), 32'd0);
    if (exp_q.size() != 0) $display("FAIL missing_pulses remaining=%0d", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
